// File: rtl/write_buffer_arbiter.sv
// Write-through buffer with read-priority arbitration onto a single-ported
// main memory.
//
// A DEPTH-entry FIFO absorbs write-through traffic from the cache
// controller. It drains to memory whenever no refill read is pending. A
// refill read whose address matches a buffered write, or a write accepted in
// the same cycle, forces that write to drain first so the read sees fresh
// data. At most one memory transaction is outstanding at a time.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   wr_req/addr/data  write-through request; wr_accept = pushed this cycle
//   rd_req/addr       refill read, held until rd_valid
//   rd_valid/rd_data  one-cycle read completion with registered data
//   mem_*             main-memory strobe/address/data, mem_ready completes
//   buf_empty, busy   FIFO empty / FSM not idle

// One buffer slot: stores {addr,data} and reports a match against the
// pending refill address.
module wba_entry #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          clr,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] cmp_addr,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          hit
);
  logic valid;

  // set wins over clr: a full buffer pushing and popping the same slot
  // refills it with the new entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (set) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == cmp_addr);
endmodule

module write_buffer_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_accept,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          buf_empty,
  output logic          busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       count;
  logic [PW-1:0]       wptr, rptr;
  logic [AW-1:0]       rd_addr_q;
  logic                push, pop, full, hazard, rd_go;
  logic [DEPTH-1:0]    e_hit;
  logic [DEPTH-1:0][AW-1:0] e_addr;
  logic [DEPTH-1:0][DW-1:0] e_data;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      wba_entry #(.AW(AW), .DW(DW)) u_ent (
        .clk      (clk),
        .reset    (reset),
        .set      (push && (wptr == PW'(i))),
        .clr      (pop && (rptr == PW'(i))),
        .in_addr  (wr_addr),
        .in_data  (wr_data),
        .cmp_addr (rd_addr),
        .addr     (e_addr[i]),
        .data     (e_data[i]),
        .hit      (e_hit[i])
      );
    end
  endgenerate

  assign pop  = (state == WRITE) && mem_ready;
  assign full = (count == CW'(DEPTH));
  // A pop in the same cycle frees the head slot, so a full buffer can still
  // accept. Gated by reset so nothing is acknowledged while held in reset.
  assign wr_accept = reset && wr_req && (!full || pop);
  assign push      = wr_accept;

  assign hazard = (|e_hit) || (push && (wr_addr == rd_addr));
  // rd_req is still high during the rd_valid cycle; masking it stops the
  // completed read from being reissued.
  assign rd_go  = rd_req && !rd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_go && !hazard)    state_nxt = READ;
        else if (rd_go)          state_nxt = WRITE;
        else if (count != '0)    state_nxt = WRITE;
      end
      READ:    if (mem_ready) state_nxt = IDLE;
      WRITE:   if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (state == IDLE && state_nxt == READ) rd_addr_q <= rd_addr;
      rd_valid <= (state == READ) && mem_ready;
      if ((state == READ) && mem_ready) rd_data <= mem_rdata;
    end
  end

  // Strobes decode straight from state: both low in IDLE, mutually
  // exclusive, and held for the whole transaction. The WRITE head is stable
  // because it only pops on the completing edge.
  always_comb begin
    mem_read  = (state == READ);
    mem_write = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == READ) mem_addr = rd_addr_q;
    if (state == WRITE) begin
      mem_addr  = e_addr[rptr];
      mem_wdata = e_data[rptr];
    end
  end

  assign buf_empty = (count == '0);
  assign busy      = (state != IDLE);
endmodule
